// File: rtl/ifa_arb_pkg.sv
// rtl/ifa_arb_pkg.sv - shared types and constants for the ifa bus arbiter
package ifa_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } arb_state_t;

    localparam logic [1:0] MODE_READ  = 2'd0;
    localparam logic [1:0] MODE_WRITE = 2'd1;

    localparam int DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts at ptr
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          valid
);

    logic [IW:0] slot;
    logic        found;

    // Walk the requesters in priority order ptr, ptr+1, ... wrapping at N.
    always_comb begin
        win   = '0;
        found = 1'b0;
        slot  = '0;
        for (int i = 0; i < N; i++) begin
            slot = {1'b0, ptr} + (IW+1)'(i);
            if (slot >= (IW+1)'(N)) begin
                slot = slot - (IW+1)'(N);
            end
            if (!found && req[slot[IW-1:0]]) begin
                win[slot[IW-1:0]] = 1'b1;
                found             = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/ifa_bus_arbiter.sv
// rtl/ifa_bus_arbiter.sv - round-robin ifa bus arbiter/sequencer; IFA_ARB_TIMEOUT_EN adds a WAIT timeout abort
module ifa_bus_arbiter
    import ifa_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*2-1:0]      mode_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      err_o,
    output logic                      bus_req,
    output logic                      bus_gnt,
    output logic                      bus_start,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [1:0]                bus_mode,
    input  logic                      bus_rdy
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t          state, state_d;
    logic [IW-1:0]       rr_ptr, win_idx, pick_idx, next_ptr;
    logic [NUM_REQ-1:0]  pick_win;
    logic                pick_valid, pick, finish, timeout;
    logic [NUM_REQ-1:0]  gnt_d, done_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [1:0]          mode_d;
    logic                start_d;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (req_i),
        .ptr   (rr_ptr),
        .win   (pick_win),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_win[i]) begin
                pick_idx = IW'(i);
            end
        end
    end

    // Arbitration is held off while done_o is up so the finished master can drop its request first.
    assign pick     = (state == IDLE) && !(|done_o) && pick_valid;
    assign finish   = (state == WAIT) && (bus_rdy || timeout);
    assign next_ptr = (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + IW'(1);

`ifdef IFA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT+1);
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign timeout = (state == WAIT) && !bus_rdy && (wait_cnt == CW'(TIMEOUT-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else begin
            err_o <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            win_idx <= '0;
        end else begin
            state <= state_d;
            if (pick) begin
                win_idx <= pick_idx;
            end
            if (finish) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (pick) state_d = GRANT;
            GRANT:   state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next-cycle output values; the bus_addr/bus_mode registers double as the latched request.
    always_comb begin
        gnt_d   = gnt_o;
        addr_d  = bus_addr;
        mode_d  = bus_mode;
        start_d = 1'b0;
        done_d  = '0;
        case (state)
            IDLE: begin
                gnt_d  = pick ? pick_win : '0;
                addr_d = pick ? addr_i[pick_idx*ADDR_W +: ADDR_W] : '0;
                mode_d = pick ? mode_i[pick_idx*2 +: 2] : 2'd0;
            end
            GRANT: start_d = 1'b1;
            START: start_d = 1'b0;
            WAIT: begin
                if (finish) begin
                    gnt_d  = '0;
                    addr_d = '0;
                    mode_d = 2'd0;
                    done_d = gnt_o;
                end
            end
            default: begin
                gnt_d  = '0;
                addr_d = '0;
                mode_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_o     <= '0;
            done_o    <= '0;
            bus_req   <= 1'b0;
            bus_gnt   <= 1'b0;
            bus_start <= 1'b0;
            bus_addr  <= '0;
            bus_mode  <= 2'd0;
        end else begin
            gnt_o     <= gnt_d;
            done_o    <= done_d;
            bus_req   <= |gnt_d;
            bus_gnt   <= |gnt_d;
            bus_start <= start_d;
            bus_addr  <= addr_d;
            bus_mode  <= mode_d;
        end
    end

endmodule

// File: tb/tb_ifa_bus_arbiter.sv
// tb/tb_ifa_bus_arbiter.sv - self-checking bench for ifa_bus_arbiter
module tb_ifa_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_i;
    logic [N*AW-1:0] addr_i;
    logic [N*2-1:0]  mode_i;
    logic [N-1:0]    gnt_o, done_o;
    logic            err_o, bus_req, bus_gnt, bus_start;
    logic [AW-1:0]   bus_addr;
    logic [1:0]      bus_mode;
    logic            bus_rdy;
    logic            rdy_man;
    logic            rdy_auto = 1'b0;
    logic            auto_en;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    assign bus_rdy = rdy_man | rdy_auto;

    ifa_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .addr_i    (addr_i),
        .mode_i    (mode_i),
        .gnt_o     (gnt_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .bus_start (bus_start),
        .bus_addr  (bus_addr),
        .bus_mode  (bus_mode),
        .bus_rdy   (bus_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Zero-wait memory: rdy answers in the cycle after it sees start.
    logic st_seen;
    always @(posedge clk) begin
        st_seen = bus_start;
        #1 rdy_auto = auto_en && st_seen;
    end

    // Transaction-level model: m_age counts cycles since the grant appeared.
    bit            m_busy, m_was_done;
    int            m_win, m_age, m_ptr;
    logic [AW-1:0] m_addr;
    logic [1:0]    m_mode;
    logic [N-1:0]  e_gnt, e_done;
    logic          e_err, e_start, e_own;
    logic [AW-1:0] e_addr;
    logic [1:0]    e_mode;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_age = 0; m_ptr = 0; e_done = '0; e_err = 1'b0;
        end else begin
            m_was_done = (e_done != '0);
            e_done = '0;
            e_err  = 1'b0;
            if (m_busy) begin
                if (m_age >= 2 && bus_rdy) begin
                    m_busy = 1'b0; e_done[m_win] = 1'b1; m_ptr = (m_win + 1) % N;
                end
`ifdef IFA_ARB_TIMEOUT_EN
                else if (m_age == TO + 1) begin
                    m_busy = 1'b0; e_done[m_win] = 1'b1; e_err = 1'b1; m_ptr = (m_win + 1) % N;
                end
`endif
                else begin
                    m_age++;
                end
            end else if (!m_was_done && req_i != '0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req_i[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
                end
                m_busy = 1'b1;
                m_age  = 0;
                m_addr = addr_i[m_win*AW +: AW];
                m_mode = mode_i[m_win*2 +: 2];
            end
        end
        e_gnt = '0;
        if (m_busy) e_gnt[m_win] = 1'b1;
        e_own   = m_busy;
        e_start = m_busy && (m_age == 1);
        e_addr  = m_busy ? m_addr : '0;
        e_mode  = m_busy ? m_mode : 2'd0;
    end

    always @(negedge clk) begin
        check("gnt_o", gnt_o, e_gnt);
        check("done_o", done_o, e_done);
        check("err_o", err_o, e_err);
        check("bus_req", bus_req, e_own);
        check("bus_gnt", bus_gnt, e_own);
        check("bus_start", bus_start, e_start);
        check("bus_addr", bus_addr, e_addr);
        check("bus_mode", bus_mode, e_mode);
    end

    logic [N-1:0] done_val[$];
    int           done_cyc[$];
    int           start_n = 0;
    always @(negedge clk) begin
        if (done_o != '0) begin
            done_val.push_back(done_o);
            done_cyc.push_back(cyc);
        end
        if (bus_start) start_n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt();
        int k = 0;
        while (gnt_o == '0 && k < 40) begin
            tick();
            k++;
        end
        check("gnt_within_bound", {31'b0, gnt_o != '0}, 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] exp_order [5];
        int base, nd;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1; req_i = '0; addr_i = '0; mode_i = '0; rdy_man = 1'b0; auto_en = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_gnt", gnt_o, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_req", bus_req, 0);
        check("rst_err", err_o, 0);

        // Stray rdy while idle.
        rdy_man = 1'b1; tick(); tick(); rdy_man = 1'b0; tick();
        check("stray_idle_done", done_val.size(), 0);

        // Single requester 1, rdy two cycles after start, stray rdy in GRANT.
        addr_i = {8'h44, 8'h77, 8'h3C, 8'h11};
        mode_i = {2'd1, 2'd1, 2'd0, 2'd1};
        req_i  = 4'b0010;
        tick();
        check("single_gnt", gnt_o, 4'b0010);
        check("single_addr", bus_addr, 8'h3C);
        check("single_mode", bus_mode, 0);
        rdy_man = 1'b1; tick();
        rdy_man = 1'b0; req_i = '0;
        check("single_start", bus_start, 1);
        tick(); tick();
        rdy_man = 1'b1; tick();
        rdy_man = 1'b0;
        check("single_done", done_o, 4'b0010);
        tick(); tick();
        check("single_start_count", start_n, 1);
        check("single_done_count", done_val.size(), 1);

        // Requester 2 drops request and changes address during WAIT.
        addr_i[2*AW +: AW] = 8'hA5; mode_i[5:4] = 2'd1; req_i = 4'b0100;
        wait_gnt();
        check("hold_gnt", gnt_o, 4'b0100);
        tick(); tick();
        req_i = '0; addr_i[2*AW +: AW] = 8'h5A; mode_i[5:4] = 2'd3;
        tick(); tick();
        check("hold_addr", bus_addr, 8'hA5);
        check("hold_mode", bus_mode, 1);
        rdy_man = 1'b1; tick();
        rdy_man = 1'b0;
        check("hold_done", done_o, 4'b0100);
        tick(); tick();

        // Reset during WAIT: pointer returns to 0.
        req_i = 4'b1000;
        wait_gnt();
        check("rst_mid_gnt", gnt_o, 4'b1000);
        tick(); tick();
        req_i = '0; rst = 1'b1; nd = done_val.size(); tick();
        rst = 1'b0;
        check("rst_mid_gnt_off", gnt_o, 0);
        check("rst_mid_start_off", bus_start, 0);
        check("rst_mid_addr", bus_addr, 0);
        tick(); tick();
        check("rst_mid_no_done", done_val.size(), nd);
        req_i = 4'b1001;
        wait_gnt();
        check("rst_next_gnt", gnt_o, 4'b0001);
        req_i = '0;
        tick(); tick();
        rdy_man = 1'b1; tick();
        rdy_man = 1'b0;
        check("rst_next_done", done_o, 4'b0001);
        tick(); tick();

        // All four requesting, zero-wait memory.
        rst = 1'b1; tick(); rst = 1'b0;
        base = done_val.size();
        auto_en = 1'b1; req_i = 4'b1111;
        for (int k = 0; k < 60 && done_val.size() < base + 5; k++) tick();
        req_i = '0;
        check("rr_done_count", done_val.size() >= base + 5, 1);
        repeat (12) tick();
        auto_en = 1'b0;
        tick(); tick();
        if (done_val.size() >= base + 5) begin
            for (int k = 0; k < 5; k++) check("rr_order", done_val[base+k], exp_order[k]);
            for (int k = 1; k < 5; k++) check("rr_spacing", done_cyc[base+k] - done_cyc[base+k-1], 5);
        end

`ifdef IFA_ARB_TIMEOUT_EN
        // No rdy: abort after 15 WAIT cycles. Pointer is 1 here.
        req_i = 4'b0010;
        wait_gnt();
        req_i = '0;
        repeat (16) tick();
        check("to_waiting_err", err_o, 0);
        check("to_waiting_gnt", gnt_o, 4'b0010);
        tick();
        check("to_err", err_o, 1);
        check("to_done", done_o, 4'b0010);
        tick(); tick();
        // rdy on WAIT cycle 15 wins over the timeout.
        req_i = 4'b0100;
        wait_gnt();
        req_i = '0;
        repeat (16) tick();
        rdy_man = 1'b1; tick();
        rdy_man = 1'b0;
        check("to_rdy_err", err_o, 0);
        check("to_rdy_done", done_o, 4'b0100);
        tick(); tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
